// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready, shifts it out MSB-first,
// appends GAP zero bits, and counts the overlapping "1101" completions it drives.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] expect_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers at a rising edge where load_valid && load_ready.
  // load_ready depends on the state register only, so the producer must hold
  // load_valid and data_in until it sees the transfer.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [2:0]       hist_q;
  logic             match;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          sreg_d  = data_in;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_q << 1;
        bit_d  = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          gap_d   = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      dout       <= (state_d == S_SHIFT) && sreg_d[WIDTH-1];
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_SHIFT) && (bit_d == BIT_LAST);
    end
  end

  // History sees every driven bit, idle and gap zeros included, so matches span frames.
  assign match = (hist_q == 3'b110) && dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q     <= 3'b000;
      expect_cnt <= '0;
    end else begin
      hist_q <= {hist_q[1:0], dout};
      if (match && (expect_cnt != {CNT_W{1'b1}}))
        expect_cnt <= expect_cnt + 1'b1;
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: three instances (GAP=2, GAP=0, CNT_W=2) driven
// from a frame table plus hand-written multi-cycle sequences.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lv [3];
  logic [7:0] din [3];
  logic       rdy_w [3];
  logic       dout_w [3];
  logic       busy_w [3];
  logic       fd_w [3];
  logic [7:0] cnt_w [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [1:0] st_w [3];
  int         gaps [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .GAP(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .load_valid(lv[0]), .load_ready(rdy_w[0]),
    .dout(dout_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]), .expect_cnt(cnt0), .state_dbg(st_w[0]));
  seq_pattern_tx #(.WIDTH(8), .GAP(0), .CNT_W(8)) u_g0 (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .load_valid(lv[1]), .load_ready(rdy_w[1]),
    .dout(dout_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]), .expect_cnt(cnt1), .state_dbg(st_w[1]));
  seq_pattern_tx #(.WIDTH(8), .GAP(2), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .load_valid(lv[2]), .load_ready(rdy_w[2]),
    .dout(dout_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]), .expect_cnt(cnt2), .state_dbg(st_w[2]));

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {6'b0, cnt2};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, " idle dout"}, 32'(dout_w[u]), 32'd0);
    check({tag, " idle busy"}, 32'(busy_w[u]), 32'd0);
    check({tag, " idle ready"}, 32'(rdy_w[u]), 32'd1);
    check({tag, " idle frame_done"}, 32'(fd_w[u]), 32'd0);
  endtask

  // Entered right after the accepting edge; returns at the negedge of the following IDLE cycle.
  task automatic run_frame(input int u, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("u%0d bit%0d dout", u, i), 32'(dout_w[u]), 32'(d[7-i]));
      check($sformatf("u%0d bit%0d busy", u, i), 32'(busy_w[u]), 32'd1);
      check($sformatf("u%0d bit%0d ready", u, i), 32'(rdy_w[u]), 32'd0);
      check($sformatf("u%0d bit%0d frame_done", u, i), 32'(fd_w[u]), (i == 7) ? 32'd1 : 32'd0);
    end
    for (int g = 0; g < gaps[u]; g++) begin
      @(negedge clk);
      check($sformatf("u%0d gap%0d dout", u, g), 32'(dout_w[u]), 32'd0);
      check($sformatf("u%0d gap%0d busy", u, g), 32'(busy_w[u]), 32'd1);
      check($sformatf("u%0d gap%0d ready", u, g), 32'(rdy_w[u]), 32'd0);
    end
    @(negedge clk);
    check_idle(u, $sformatf("u%0d post", u));
  endtask

  // Called at a negedge; waits (bounded) for ready, transfers one word, then checks the frame.
  task automatic send(input int u, input logic [7:0] d);
    int t = 0;
    while (!rdy_w[u] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_w[u]) begin
      errors++;
      $display("FAIL u%0d ready timeout: got 0 expected 1", u);
    end
    lv[u]  = 1'b1;
    din[u] = d;
    @(posedge clk);
    #1;
    lv[u]  = 1'b0;
    din[u] = 8'($urandom_range(0, 255));
    run_frame(u, d);
  endtask

  initial begin
    gaps = '{2, 0, 2};
    vecs[0] = '{8'hD0, 8'd1};
    vecs[1] = '{8'hDB, 8'd3};
    vecs[2] = '{8'h00, 8'd3};
    vecs[3] = '{8'hFF, 8'd3};
    vecs[4] = '{8'h6D, 8'd5};
    vecs[5] = '{8'hB6, 8'd6};
    for (int u = 0; u < 3; u++) begin
      lv[u]  = 1'b0;
      din[u] = 8'h00;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check_idle(u, $sformatf("u%0d reset", u));
      check($sformatf("u%0d reset cnt", u), 32'(cnt_w[u]), 32'd0);
    end

    // Frame table on the GAP=2 instance; expected counts are cumulative.
    for (int v = 0; v < 6; v++) begin
      send(0, vecs[v].data);
      check($sformatf("table%0d cnt", v), 32'(cnt_w[0]), 32'(vecs[v].exp_cnt));
    end

    // Held valid with a changing word: second word only taken in the IDLE cycle.
    lv[0]  = 1'b1;
    din[0] = 8'hD0;
    @(posedge clk);
    #1;
    din[0] = 8'h5A;
    run_frame(0, 8'hD0);
    check("held first cnt", 32'(cnt_w[0]), 32'd7);
    @(posedge clk);
    #1;
    lv[0]  = 1'b0;
    din[0] = 8'h00;
    run_frame(0, 8'h5A);
    check("held second cnt", 32'(cnt_w[0]), 32'd8);

    // Cross-frame match: 0x03 then 0x80; counts only when no gap separates them.
    send(1, 8'h03);
    check("g0 first cnt", 32'(cnt_w[1]), 32'd0);
    send(1, 8'h80);
    check("g0 cross cnt", 32'(cnt_w[1]), 32'd1);
    send(0, 8'h03);
    send(0, 8'h80);
    check("gap2 cross cnt", 32'(cnt_w[0]), 32'd8);

    // Saturation with a 2-bit counter.
    for (int f = 0; f < 4; f++) begin
      send(2, 8'hD0);
      check($sformatf("sat frame%0d cnt", f), 32'(cnt_w[2]), (f < 3) ? 32'(f + 1) : 32'd3);
    end

    // Reset in the middle of 0xFF, at the edge after bit 3.
    lv[0]  = 1'b1;
    din[0] = 8'hFF;
    @(posedge clk);
    #1;
    lv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort bit%0d dout", i), 32'(dout_w[0]), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "abort");
    check("abort cnt", 32'(cnt_w[0]), 32'd0);
    check("abort sat cnt", 32'(cnt_w[2]), 32'd0);
    @(negedge clk);
    check("abort no late frame_done", 32'(fd_w[0]), 32'd0);
    send(0, 8'hD0);
    check("after abort cnt", 32'(cnt_w[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit stream consumed by the team's Mealy "1101" sequence detector.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, then inserts a programmable run of zero gap bits.
- Keeps a reference count of overlapping "1101" occurrences it has driven, so benches can scoreboard the detector against it directly.

Parameters:
WIDTH, 8, bits per transmitted word (>=1)
GAP, 2, zero bits driven after each word before returning to IDLE (>=0)
CNT_W, 8, width of expect_cnt

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
data_in  input  WIDTH  word to transmit; sampled only on handshake
load_valid  input  1  producer has a word on data_in
load_ready  output  1  block can accept a word this cycle
dout  output  1  serial stream, registered, meaningful every cycle
busy  output  1  word or gap in progress
frame_done  output  1  one-cycle pulse coincident with last data bit on dout
expect_cnt  output  CNT_W  saturating count of "1101" completions driven on dout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge) takes priority over everything:
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - dout=0, busy=0, frame_done=0, expect_cnt=0, 3-bit history register=000.
  - load_ready=1 from the first cycle after reset.
  - A word in flight is discarded. No partial frame_done.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: load_ready=1, dout=0, busy=0. On load_valid=1 at an edge, capture data_in and go to SHIFT. Otherwise stay.
  - SHIFT: load_ready=0, busy=1. dout = current MSB of the shift register; shift left each cycle. After WIDTH cycles in SHIFT, go to GAP if GAP>0, else IDLE.
  - GAP: dout=0, busy=1, load_ready=0. Stay GAP cycles, then go to IDLE.
- Latency and timing:
  - Handshake accepted at edge k. Bit data_in[WIDTH-1-i] is on dout during cycle k+1+i, for i=0..WIDTH-1.
  - frame_done=1 only during the cycle holding bit 0.
- Throughput: at least one IDLE cycle between frames (dout=0 in it). Minimum frame period is WIDTH+GAP+1 cycles.
- Handshake rules:
  - load_valid while load_ready=0 is ignored; the producer must hold it.
  - data_in changes after acceptance have no effect.
  - load_ready is a function of state only; no combinational path from load_valid.
- Reference counter:
  - A history register holds the last 3 dout values and shifts every cycle, including IDLE and GAP cycles.
  - Match when history==110 (oldest to newest) and current dout==1; overlapping matches are allowed.
  - On a match, expect_cnt increments at the end of that cycle, i.e. in the same cycle the detector's y is high.
  - expect_cnt saturates at 2^CNT_W-1; no wrap-around.
- Matches spanning frames count, because IDLE and GAP zeros are part of the stream. The history is not cleared between frames.
- All outputs are registered or decoded from registered state; no combinational input-to-output paths.

Test Plan:
1. Reset, then load 0xD0 (WIDTH=8, GAP=2) -> dout 1,1,0,1,0,0,0,0 in cycles k+1..k+8. frame_done in k+8. busy high k+1..k+10. load_ready back to 1 at k+11. expect_cnt=1.
2. Load 0xDB -> stream 1,1,0,1,1,0,1,1. Overlapping matches at bits 3 and 6. expect_cnt increments by 2.
3. Cross-frame check with GAP=0: load 0x03, then 0x80 at the first ready.
   - Stream ...1,1,0(IDLE),1 -> expect_cnt increments by 1.
   - Same sequence with GAP=2 (1,1,0,0,0,1) -> no increment.
4. Hold load_valid=1 with a new data_in throughout a frame -> second word accepted only in the IDLE cycle. data_in changes mid-frame do not alter dout.
5. Load 0xFF; drive rst_n=0 at the edge after bit 3 -> next cycle dout=0, busy=0, load_ready=1, expect_cnt=0, no frame_done. A new load 0xD0 then transmits cleanly with expect_cnt=1.
6. CNT_W=2: drive 4 frames of 0xD0 -> expect_cnt reads 1,2,3,3 (saturated).
